// File: rtl/banked_register_file.sv
// rtl/banked_register_file.sv - banked register file with MSP/PSP R13 banking, R15 branch output and write bypass
// R15 is never stored; physical slot 15 holds PSP so storage is a flat 16-entry array.
module banked_register_file #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          NUM_RD_PORTS = 3,
  parameter logic [31:0] MSP_RESET    = 32'h2000_1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD_PORTS*4-1:0]      rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  input  logic                           wr0_en,
  input  logic [3:0]                     wr0_addr,
  input  logic [DATA_WIDTH-1:0]          wr0_data,
  input  logic                           wr1_en,
  input  logic [3:0]                     wr1_addr,
  input  logic [DATA_WIDTH-1:0]          wr1_data,
  input  logic                           sp_sel,
  input  logic [DATA_WIDTH-1:0]          pc_in,
  output logic                           pc_wr_valid,
  output logic [DATA_WIDTH-1:0]          pc_wr_data,
  output logic                           wr_conflict
);

  localparam logic [DATA_WIDTH-1:0] SP_MASK  = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [DATA_WIDTH-1:0] PC_MASK  = {{(DATA_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [DATA_WIDTH-1:0] MSP_INIT = DATA_WIDTH'(MSP_RESET) & SP_MASK;
  localparam logic [3:0]            ADDR_SP  = 4'd13;
  localparam logic [3:0]            ADDR_PC  = 4'd15;

  logic [DATA_WIDTH-1:0] r_regs [16];
  logic                  r_pc_wr_valid;
  logic [DATA_WIDTH-1:0] r_pc_wr_data;
  logic                  r_wr_conflict;

  logic                  w_wr0_store;
  logic                  w_wr1_store;
  logic                  w_wr0_pc;
  logic                  w_wr1_pc;
  logic [3:0]            w_wr0_idx;
  logic [3:0]            w_wr1_idx;
  logic [DATA_WIDTH-1:0] w_wr0_data;
  logic [DATA_WIDTH-1:0] w_wr1_data;

  function automatic logic [3:0] phys_idx(input logic [3:0] addr, input logic sel);
    return (addr == ADDR_SP && sel) ? ADDR_PC : addr;
  endfunction

  assign w_wr0_store = wr0_en && (wr0_addr != ADDR_PC);
  assign w_wr1_store = wr1_en && (wr1_addr != ADDR_PC);
  assign w_wr0_pc    = wr0_en && (wr0_addr == ADDR_PC);
  assign w_wr1_pc    = wr1_en && (wr1_addr == ADDR_PC);
  assign w_wr0_idx   = phys_idx(wr0_addr, sp_sel);
  assign w_wr1_idx   = phys_idx(wr1_addr, sp_sel);
  assign w_wr0_data  = (wr0_addr == ADDR_SP) ? (wr0_data & SP_MASK) : wr0_data;
  assign w_wr1_data  = (wr1_addr == ADDR_SP) ? (wr1_data & SP_MASK) : wr1_data;

  // wr1 is applied after wr0 so it wins on a same-entry collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_regs[13] <= MSP_INIT;
      r_regs[14] <= '1;
    end else begin
      if (w_wr0_store) r_regs[w_wr0_idx] <= w_wr0_data;
      if (w_wr1_store) r_regs[w_wr1_idx] <= w_wr1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_wr_valid <= 1'b0;
      r_pc_wr_data  <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      r_pc_wr_valid <= w_wr0_pc || w_wr1_pc;
      if (w_wr1_pc)      r_pc_wr_data <= wr1_data & PC_MASK;
      else if (w_wr0_pc) r_pc_wr_data <= wr0_data & PC_MASK;
      r_wr_conflict <= wr0_en && wr1_en && (wr0_addr == wr1_addr);
    end
  end

  assign pc_wr_valid = r_pc_wr_valid;
  assign pc_wr_data  = r_pc_wr_data;
  assign wr_conflict = r_wr_conflict;

  // Same-cycle writes are forwarded so a reader never sees a stale value.
  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [3:0]            w_ra;
    logic [DATA_WIDTH-1:0] w_rd;

    assign w_ra = rd_addr[4*k +: 4];

    always_comb begin
      w_rd = r_regs[phys_idx(w_ra, sp_sel)];
      if (w_ra == ADDR_PC)                       w_rd = pc_in;
      else if (w_wr1_store && wr1_addr == w_ra)  w_rd = w_wr1_data;
      else if (w_wr0_store && wr0_addr == w_ra)  w_rd = w_wr0_data;
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
  end

endmodule

// File: tb/tb_banked_register_file.sv
// tb/tb_banked_register_file.sv - table-driven bench with registered-output scoreboard for banked_register_file
module tb_banked_register_file;

  typedef struct {
    logic            w0e;
    logic [3:0]      w0a;
    logic [31:0]     w0d;
    logic            w1e;
    logic [3:0]      w1a;
    logic [31:0]     w1d;
    logic            sp;
    logic [31:0]     pc;
    logic [2:0][3:0] ra;
    logic [2:0][31:0] er;
    logic            epv;
    logic [31:0]     epd;
    logic            ec;
  } vec_t;

  typedef struct packed {
    logic        pv;
    logic [31:0] pd;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] rd_addr = '0;
  logic [95:0] rd_data;
  logic        wr0_en = 1'b0, wr1_en = 1'b0;
  logic [3:0]  wr0_addr = '0, wr1_addr = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;
  logic        sp_sel = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_wr_valid, wr_conflict;
  logic [31:0] pc_wr_data;

  logic [15:0] b_rd_addr = '0;
  logic [63:0] b_rd_data;
  logic        b_wr0_en = 1'b0, b_wr1_en = 1'b0;
  logic [3:0]  b_wr0_addr = '0, b_wr1_addr = '0;
  logic [15:0] b_wr0_data = '0, b_wr1_data = '0;
  logic        b_pc_wr_valid, b_wr_conflict;
  logic [15:0] b_pc_wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];
  exp_t sb[$];
  logic [31:0] last_pd;

  banked_register_file dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sp_sel(sp_sel), .pc_in(pc_in), .pc_wr_valid(pc_wr_valid),
    .pc_wr_data(pc_wr_data), .wr_conflict(wr_conflict)
  );

  banked_register_file #(.DATA_WIDTH(16), .NUM_RD_PORTS(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
    .sp_sel(sp_sel), .pc_in(pc_in[15:0]), .pc_wr_valid(b_pc_wr_valid),
    .pc_wr_data(b_pc_wr_data), .wr_conflict(b_wr_conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w0e, input logic [3:0] w0a, input logic [31:0] w0d,
                              input logic w1e, input logic [3:0] w1a, input logic [31:0] w1d,
                              input logic sp, input logic [31:0] pc,
                              input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                              input logic pv, input logic [31:0] pd, input logic c);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.sp = sp; v.pc = pc;
    v.ra[0] = a0; v.ra[1] = a1; v.ra[2] = a2;
    v.er[0] = e0; v.er[1] = e1; v.er[2] = e2;
    v.epv = pv; v.epd = pd; v.ec = c;
    return v;
  endfunction

  // Called just after a rising edge; reads checked at the falling edge, registered outputs after the next rise.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
    wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
    sp_sel = v.sp; pc_in = v.pc;
    rd_addr = {v.ra[2], v.ra[1], v.ra[0]};
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s rd%0d", tag, k), rd_data[k*32 +: 32], v.er[k]);
    sb.push_back('{pv: v.epv, pd: v.epd, c: v.ec});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " pc_wr_valid"}, {31'd0, pc_wr_valid}, {31'd0, e.pv});
    chk({tag, " pc_wr_data"}, pc_wr_data, e.pd);
    chk({tag, " wr_conflict"}, {31'd0, wr_conflict}, {31'd0, e.c});
    wr0_en = 1'b0;
    wr1_en = 1'b0;
  endtask

  function automatic logic [31:0] align(input logic [3:0] a, input logic [31:0] d);
    return (a == 4'd13) ? (d & 32'hFFFF_FFFC) : d;
  endfunction

  initial begin
    vecs.push_back(mk(0,0,0,            0,0,0,            0,32'h0,   0,12,14, 0,0,32'hFFFF_FFFF,               0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,            0,32'h200, 13,5,15, 32'h2000_1000,0,32'h200,       0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,            1,32'h0,   13,13,1, 0,0,0,                         0,0,0));
    vecs.push_back(mk(1,13,32'h3007,    0,0,0,            1,32'h0,   13,0,14, 32'h3004,0,32'hFFFF_FFFF,      0,0,0));
    vecs.push_back(mk(1,13,32'h4000,    0,0,0,            0,32'h200, 13,14,15, 32'h4000,32'hFFFF_FFFF,32'h200, 0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,            1,32'h0,   13,13,2, 32'h3004,32'h3004,0,           0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,            0,32'h0,   13,0,0,  32'h4000,0,0,                  0,0,0));
    vecs.push_back(mk(1,4,32'h11,       1,4,32'h22,       0,32'h0,   4,4,3,   32'h22,32'h22,0,               0,0,1));
    vecs.push_back(mk(0,0,0,            0,0,0,            0,32'h0,   4,4,4,   32'h22,32'h22,32'h22,          0,0,0));
    vecs.push_back(mk(1,15,32'h101,     0,0,0,            0,32'h200, 15,15,4, 32'h200,32'h200,32'h22,        1,32'h100,0));
    vecs.push_back(mk(0,0,0,            0,0,0,            0,32'h200, 15,4,0,  32'h200,32'h22,0,              0,32'h100,0));
    vecs.push_back(mk(1,15,32'h333,     1,15,32'h555,     0,32'h300, 15,0,4,  32'h300,0,32'h22,              1,32'h554,1));
    vecs.push_back(mk(0,0,0,            1,15,32'h777,     0,32'h300, 15,4,0,  32'h300,32'h22,0,              1,32'h776,0));
    vecs.push_back(mk(0,0,0,            0,0,0,            0,32'h300, 15,4,0,  32'h300,32'h22,0,              0,32'h776,0));
    vecs.push_back(mk(1,13,32'hAAAB,    1,13,32'hBBBF,    1,32'h0,   13,4,0,  32'hBBBC,32'h22,0,             0,32'h776,1));
    vecs.push_back(mk(0,0,0,            0,0,0,            1,32'h0,   13,14,0, 32'hBBBC,32'hFFFF_FFFF,0,      0,32'h776,0));
    vecs.push_back(mk(1,1,32'hDEADBEEF, 1,2,32'h12345678, 0,32'h0,   1,2,0,   32'hDEADBEEF,32'h12345678,0,   0,32'h776,0));
    vecs.push_back(mk(0,0,0,            0,0,0,            0,32'h0,   1,2,13,  32'hDEADBEEF,32'h12345678,32'h4000, 0,32'h776,0));
    vecs.push_back(mk(1,6,32'h66,       1,15,32'h9,       0,32'h40,  6,15,13, 32'h66,32'h40,32'h4000,        1,32'h8,0));
    vecs.push_back(mk(0,0,0,            0,0,0,            0,32'h40,  6,15,0,  32'h66,32'h40,0,               0,32'h8,0));

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc_wr_valid", {31'd0, pc_wr_valid}, 32'd0);
    chk("reset pc_wr_data", pc_wr_data, 32'd0);
    chk("reset wr_conflict", {31'd0, wr_conflict}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      logic [3:0] a;
      rd_addr = {4'(3*i+2), 4'(3*i+1), 4'(3*i)};
      #1;
      for (int k = 0; k < 3; k++) begin
        a = 4'(3*i+k);
        chk($sformatf("reset R%0d", a), rd_data[k*32 +: 32],
            (a < 4'd13) ? 32'd0 : (a == 4'd13) ? 32'h2000_1000 : 32'hFFFF_FFFF);
      end
    end
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));
    last_pd = vecs[vecs.size()-1].epd;

    for (int i = 0; i < 15; i += 2) begin
      logic [3:0] a0, a1;
      a0 = 4'(i);
      a1 = (i < 14) ? 4'(i+1) : 4'(i);
      apply(mk(1, a0, 32'(i+1), (i < 14), a1, 32'(i+2), 0, 32'h0,
               a0, a1, a0, align(a0, 32'(i+1)), align(a1, (i < 14) ? 32'(i+2) : 32'(i+1)),
               align(a0, 32'(i+1)), 0, last_pd, 0),
            $sformatf("fill%0d", i));
    end
    apply(mk(0,0,0, 0,0,0, 0,32'h0, 0,7,14, 32'd1,32'd8,32'd15, 0,last_pd,0), "multiport");
    apply(mk(0,0,0, 0,0,0, 0,32'h0, 13,13,1, 32'd12,32'd12,32'd2, 0,last_pd,0), "multiport sp");

    wr0_en = 1'b1; wr0_addr = 4'd3;  wr0_data = 32'h55;
    wr1_en = 1'b1; wr1_addr = 4'd15; wr1_data = 32'h8;
    rd_addr = {4'd0, 4'd14, 4'd3};
    @(posedge clk);
    #1;
    wr0_en = 1'b0; wr1_en = 1'b0;
    #1;
    chk("midrst R3 before", rd_data[31:0], 32'h55);
    chk("midrst pv before", {31'd0, pc_wr_valid}, 32'd1);
    chk("midrst pd before", pc_wr_data, 32'h8);
    rst_n = 1'b0;
    #1;
    chk("midrst R3 after", rd_data[31:0], 32'd0);
    chk("midrst R14 after", rd_data[63:32], 32'hFFFF_FFFF);
    chk("midrst pv after", {31'd0, pc_wr_valid}, 32'd0);
    chk("midrst pd after", pc_wr_data, 32'd0);
    wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h77;
    wr1_en = 1'b1; wr1_addr = 4'd15; wr1_data = 32'h20;
    @(posedge clk);
    #1;
    wr0_en = 1'b0; wr1_en = 1'b0;
    #1;
    chk("inreset R3 ignored", rd_data[31:0], 32'd0);
    chk("inreset pv", {31'd0, pc_wr_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h99;
    @(posedge clk);
    #1;
    wr0_en = 1'b0;
    #1;
    chk("first write after reset", rd_data[31:0], 32'h99);
    chk("first write pv", {31'd0, pc_wr_valid}, 32'd0);

    pc_in = 32'h0000_ABCD;
    b_rd_addr = {4'd13, 4'd14, 4'd0, 4'd15};
    #1;
    chk("w16 reset R15", {16'd0, b_rd_data[15:0]}, 32'hABCD);
    chk("w16 reset R0", {16'd0, b_rd_data[31:16]}, 32'h0);
    chk("w16 reset R14", {16'd0, b_rd_data[47:32]}, 32'hFFFF);
    chk("w16 reset MSP", {16'd0, b_rd_data[63:48]}, 32'h1000);
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      b_wr0_en = 1'b1; b_wr0_addr = 4'(i); b_wr0_data = 16'(i+1);
      @(posedge clk);
      #1;
    end
    b_wr0_en = 1'b0;
    b_rd_addr = {4'd13, 4'd14, 4'd7, 4'd0};
    #1;
    chk("w16 R0", {16'd0, b_rd_data[15:0]}, 32'd1);
    chk("w16 R7", {16'd0, b_rd_data[31:16]}, 32'd8);
    chk("w16 R14", {16'd0, b_rd_data[47:32]}, 32'd15);
    chk("w16 R13", {16'd0, b_rd_data[63:48]}, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
